// File: rtl/eth_pkg.sv
// Shared Ethernet header types and arbiter state encoding.
// No logic; constants, types and a small index helper only.
// Not applicable: nothing here carries data or backpressure.
package eth_pkg;

  localparam int MAC_WIDTH     = 48;
  localparam int ETHTYPE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [MAC_WIDTH-1:0]     dest_mac;
    logic [MAC_WIDTH-1:0]     src_mac;
    logic [ETHTYPE_WIDTH-1:0] eth_type;
  } hdr_t;

  // Index that follows idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker with a rotating priority pointer.
// Grant is combinational from req; pointer moves on the clock after a taken grant.
// No backpressure: the owner decides when a grant is taken via advance.
module rr_arbiter
  import eth_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Highest priority belongs to the entry at ptr; it moves past each winner.
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // Scan requesters starting at the pointer, wrapping, and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // A taken grant makes the winner lowest priority for the next pick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_vld) begin
      ptr <= IDX_W'(rr_next(int'(grant_idx), N));
    end
  end

endmodule

// File: rtl/eth_axis_frame_arbiter.sv
// Whole-frame round-robin mux of S_COUNT header+AXI-Stream sources onto one TX path.
// Header out 1 cycle after grant; payload is a 0-cycle pass-through; >=1 idle cycle between frames.
// m_hdr_ready stalls the header, m_tready/s_tvalid stall payload; losers see ready low throughout.
module eth_axis_frame_arbiter
  import eth_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic [S_COUNT-1:0]                s_hdr_valid,
  output logic [S_COUNT-1:0]                s_hdr_ready,
  input  logic [S_COUNT*MAC_WIDTH-1:0]      s_dest_mac,
  input  logic [S_COUNT*MAC_WIDTH-1:0]      s_src_mac,
  input  logic [S_COUNT*ETHTYPE_WIDTH-1:0]  s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0]     s_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]     s_tkeep,
  input  logic [S_COUNT-1:0]                s_tvalid,
  input  logic [S_COUNT-1:0]                s_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]     s_tuser,
  output logic [S_COUNT-1:0]                s_tready,

  output logic                              m_hdr_valid,
  input  logic                              m_hdr_ready,
  output logic [MAC_WIDTH-1:0]              m_dest_mac,
  output logic [MAC_WIDTH-1:0]              m_src_mac,
  output logic [ETHTYPE_WIDTH-1:0]          m_eth_type,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [KEEP_WIDTH-1:0]             m_tkeep,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic [USER_WIDTH-1:0]             m_tuser,
  input  logic                              m_tready,

  output logic                              busy,
  output logic [$clog2(S_COUNT)-1:0]        grant_index
);

  localparam int IDX_W = $clog2(S_COUNT);

  arb_state_t state;
  hdr_t       hdr_q;

  // Per-source views of the flattened input buses.
  hdr_t                  src_hdr   [S_COUNT];
  logic [DATA_WIDTH-1:0] src_tdata [S_COUNT];
  logic [KEEP_WIDTH-1:0] src_tkeep [S_COUNT];
  logic [USER_WIDTH-1:0] src_tuser [S_COUNT];

  for (genvar i = 0; i < S_COUNT; i++) begin : g_src
    assign src_hdr[i] = '{
      dest_mac: s_dest_mac[i*MAC_WIDTH +: MAC_WIDTH],
      src_mac:  s_src_mac[i*MAC_WIDTH +: MAC_WIDTH],
      eth_type: s_eth_type[i*ETHTYPE_WIDTH +: ETHTYPE_WIDTH]
    };
    assign src_tdata[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign src_tkeep[i] = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign src_tuser[i] = s_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  logic [S_COUNT-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic               arb_take;

  // Arbitration only happens in IDLE, so the pointer only moves when a frame is granted.
  assign arb_take = (state == IDLE);

  rr_arbiter #(
    .N(S_COUNT)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (s_hdr_valid),
    .advance   (arb_take),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Header is accepted in the same cycle it wins, so the ready pulse is the raw grant.
  assign s_hdr_ready = arb_take ? arb_grant : '0;

  assign m_dest_mac = hdr_q.dest_mac;
  assign m_src_mac  = hdr_q.src_mac;
  assign m_eth_type = hdr_q.eth_type;

  // Frame sequencing: capture header on grant, present it, then hold the grant until tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hdr_q       <= '0;
      m_hdr_valid <= 1'b0;
      busy        <= 1'b0;
      grant_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            hdr_q       <= src_hdr[arb_idx];
            grant_index <= arb_idx;
            m_hdr_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= HDR;
          end
        end
        HDR: begin
          if (m_hdr_ready) begin
            m_hdr_valid <= 1'b0;
            state       <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (m_tvalid && m_tready && m_tlast) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          m_hdr_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Payload path: steer the granted source straight through; everything is quiet otherwise.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tuser  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == PAYLOAD) begin
      m_tdata               = src_tdata[grant_index];
      m_tkeep               = src_tkeep[grant_index];
      m_tuser               = src_tuser[grant_index];
      m_tvalid              = s_tvalid[grant_index];
      m_tlast               = s_tlast[grant_index];
      s_tready[grant_index] = m_tready;
    end
  end

endmodule
